// File: rtl/mb_scheduler.sv
// mb_scheduler: raster-order macroblock sequencer between the extractor and the intra predictor.
module mb_scheduler #(
    parameter int LENGTH      = 1280,
    parameter int WIDTH       = 720,
    parameter int MB_SIZE_L   = 16,
    parameter int MB_SIZE_W   = 16,
    parameter int EXTRACT_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        ext_enable,
    output logic [12:0] mbnumber,
    output logic        mb_valid,
    input  logic        pred_ready,
    output logic [12:0] mb_index,
    output logic [6:0]  mb_x,
    output logic [6:0]  mb_y,
    output logic        first_in_row,
    output logic        last_in_frame,
    output logic        busy,
    output logic        frame_done
);
    localparam int MBS_X    = LENGTH / MB_SIZE_L;
    localparam int MBS_Y    = WIDTH / MB_SIZE_W;
    localparam int MB_TOTAL = MBS_X * MBS_Y;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [12:0] idx_q, idx_d;
    logic [6:0]  x_q, x_d, y_q, y_d;
    logic        last_pos, row_end;
    assign last_pos = idx_q == 13'(MB_TOTAL - 1);
    assign row_end  = x_q == 7'(MBS_X - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                idx_d   = '0;
                x_d     = '0;
                y_d     = '0;
            end
            FETCH: begin
                cnt_d   = 4'(EXTRACT_LAT - 1);
                state_d = (EXTRACT_LAT == 1) ? HOLD : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? HOLD : WAIT;
            end
            HOLD: if (pred_ready) begin
                state_d = last_pos ? DONE : FETCH;
                idx_d   = last_pos ? idx_q : idx_q + 13'd1;
                x_d     = last_pos ? x_q : (row_end ? 7'd0 : x_q + 7'd1);
                y_d     = (!last_pos && row_end) ? y_q + 7'd1 : y_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort wins over a same-cycle transfer, so the position is kept as-is
        if (abort) begin
            state_d = IDLE;
            idx_d   = idx_q;
            x_d     = x_q;
            y_d     = y_q;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end
    assign ext_enable    = state_q == FETCH;
    assign mb_valid      = state_q == HOLD;
    assign busy          = state_q != IDLE;
    assign frame_done    = state_q == DONE;
    assign mbnumber      = idx_q;
    assign mb_index      = idx_q;
    assign mb_x          = x_q;
    assign mb_y          = y_q;
    assign first_in_row  = mb_valid && x_q == 7'd0;
    assign last_in_frame = mb_valid && last_pos;
endmodule

// File: tb/tb_mb_scheduler.sv
// tb_mb_scheduler: full-size and 2x2 schedulers checked against an index/phase model every cycle.
module tb_mb_scheduler;
    logic clk = 0, reset = 1, start = 0, abort = 0, pred_ready = 1;
    always #5 clk = ~clk;
    logic        m_ext, m_valid, m_first, m_last, m_busy, m_done;
    logic [12:0] m_mbn, m_idx;
    logic [6:0]  m_x, m_y;
    logic        s_ext, s_valid, s_first, s_last, s_busy, s_done;
    logic [12:0] s_mbn, s_idx;
    logic [6:0]  s_x, s_y;
    logic [45:0] m_out, s_out;
    assign m_out = {m_ext, m_valid, m_busy, m_done, m_first, m_last, m_mbn, m_idx, m_x, m_y};
    assign s_out = {s_ext, s_valid, s_busy, s_done, s_first, s_last, s_mbn, s_idx, s_x, s_y};
    mb_scheduler u_main (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ext_enable(m_ext),
        .mbnumber(m_mbn), .mb_valid(m_valid), .pred_ready(pred_ready), .mb_index(m_idx),
        .mb_x(m_x), .mb_y(m_y), .first_in_row(m_first), .last_in_frame(m_last),
        .busy(m_busy), .frame_done(m_done)
    );
    mb_scheduler #(.LENGTH(32), .WIDTH(32), .EXTRACT_LAT(1)) u_small (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ext_enable(s_ext),
        .mbnumber(s_mbn), .mb_valid(s_valid), .pred_ready(pred_ready), .mb_index(s_idx),
        .mb_x(s_x), .mb_y(s_y), .first_in_row(s_first), .last_in_frame(s_last),
        .busy(s_busy), .frame_done(s_done)
    );
    // Model: frame running flag, done pulse, macroblock index and cycles since its extractor enable
    typedef struct {bit active; bit done; int p; int ph;} mst_t;
    mst_t ms = '{default: 0};
    mst_t ss = '{default: 0};
    int vectors = 0, miscompares = 0, cyc_n = 0;
    function automatic mst_t step(input mst_t s, input int lat, input int total,
                                  input logic rst, input logic st, input logic ab, input logic rdy);
        mst_t n = s;
        if (rst) n = '{default: 0};
        else if (ab) begin n.active = 0; n.done = 0; end
        else if (s.done) n.done = 0;
        else if (!s.active) begin
            if (st) begin n.active = 1; n.p = 0; n.ph = 0; end
        end
        else if (s.ph < lat) n.ph = s.ph + 1;
        else if (rdy) begin
            if (s.p == total - 1) begin n.active = 0; n.done = 1; end
            else begin n.p = s.p + 1; n.ph = 0; end
        end
        return n;
    endfunction
    function automatic logic [45:0] expect_out(input mst_t s, input int lat, input int mbsx, input int total);
        bit v = s.active && s.ph >= lat;
        bit e = s.active && s.ph == 0;
        return {e, v, s.active || s.done, s.done, v && (s.p % mbsx == 0), v && (s.p == total - 1),
                13'(s.p), 13'(s.p), 7'(s.p % mbsx), 7'(s.p / mbsx)};
    endfunction
    always @(posedge clk) begin
        cyc_n++;
        ms = step(ms, 2, 3600, reset, start, abort, pred_ready);
        ss = step(ss, 1, 4, reset, start, abort, pred_ready);
    end
    always @(negedge clk) begin
        vectors += 2;
        if (m_out !== expect_out(ms, 2, 80, 3600)) begin
            miscompares++;
            $display("FAIL main_model cycle %0d: got %h expected %h", cyc_n, m_out, expect_out(ms, 2, 80, 3600));
        end
        if (s_out !== expect_out(ss, 1, 2, 4)) begin
            miscompares++;
            $display("FAIL small_model cycle %0d: got %h expected %h", cyc_n, s_out, expect_out(ss, 1, 2, 4));
        end
    end
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic wait_mb(input int idx, input string nm);
        int n = 0;
        while (!(m_valid === 1'b1 && m_idx === 13'(idx)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {m_valid, m_idx}, {1'b1, 13'(idx)});
    endtask
    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask
    int t0, done_c, pulses, gaps, dones;
    int sidx[$];
    bit slast[$];
    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        chk("reset_main", m_out, 0);
        chk("reset_small", s_out, 0);
        @(negedge clk);
        // frame 1: pred_ready held high for the whole frame
        t0 = cyc_n;
        done_c = -1; pulses = 0; gaps = 0;
        pulse_start();
        for (int i = 0; i < 11000 && done_c < 0; i++) begin
            if (m_ext) begin
                if (m_mbn !== 13'(pulses)) gaps++;
                pulses++;
            end
            if (i < 8) begin
                chk("small_alternate", s_ext ^ s_valid, 1);
                if (s_valid) begin sidx.push_back(int'(s_idx)); slast.push_back(s_last); end
            end
            if (m_done) done_c = cyc_n;
            else @(negedge clk);
        end
        chk("ext_pulses", pulses, 3600);
        chk("mbnumber_gaps", gaps, 0);
        chk("frame_done_latency", done_c - t0, 10801);
        chk("busy_at_done", m_busy, 1);
        @(negedge clk);
        chk("busy_after_done", m_busy, 0);
        chk("small_count", sidx.size(), 4);
        for (int k = 0; k < sidx.size() && k < 4; k++) begin
            chk("small_index", sidx[k], k);
            chk("small_last", slast[k], k == 3);
        end
        // frame 2: ignored starts in WAIT and HOLD, stall at MB 79
        pulse_start();
        for (int n = 0; n < 100 && !(m_ext && m_mbn == 13'd5); n++) @(negedge clk);
        @(negedge clk);
        pulse_start();
        pulse_start();
        chk("start_ignored", {m_ext, m_mbn}, {1'b1, 13'd6});
        wait_mb(79, "reach_79");
        pred_ready = 0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold", {m_valid, m_ext, m_idx}, {1'b1, 1'b0, 13'd79});
        end
        pred_ready = 1;
        wait_mb(80, "reach_80");
        chk("row_wrap", {m_x, m_y, m_first}, {7'd0, 7'd1, 1'b1});
        for (int n = 0; n < 11000 && !m_done; n++) @(negedge clk);
        chk("frame2_done", m_done, 1);
        @(negedge clk);
        // frame 3: abort at MB 10 together with pred_ready
        pulse_start();
        wait_mb(10, "reach_10");
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_idle", {m_busy, m_valid, m_ext, m_done, m_mbn}, {4'b0, 13'd10});
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_done) dones++;
        end
        chk("abort_no_done", dones, 0);
        pulse_start();
        chk("restart", {m_ext, m_mbn}, {1'b1, 13'd0});
        wait_mb(2, "reach_2");
        reset = 1;
        @(negedge clk);
        chk("reset_in_hold", m_out, 0);
        reset = 0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
